// File: rtl/iobus_pkg.sv
// Shared types and constants for the OTTER I/O bus arbiter.
package iobus_pkg;

   // Transaction sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_HOLD = 2'd2,
      ST_RESP = 2'd3
   } iobus_state_t;

   // Peripheral addresses decoded by the board wrapper.
   localparam logic [31:0] ADDR_SWITCHES = 32'h1100_8000;
   localparam logic [31:0] ADDR_BUTTONS  = 32'h1100_8004;
   localparam logic [31:0] ADDR_LEDS     = 32'h1100_C000;
   localparam logic [31:0] ADDR_COUNT    = 32'h1100_C00C;

   // Width of the wait-state counter (WAIT_CYC range 0..15).
   localparam int unsigned WAIT_W = 4;

   // Two-way round-robin pick: a lone requester wins, a tie goes to the pointer.
   function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
      logic win;
      if (req == 2'b11) begin
         win = ptr;
      end else begin
         win = req[1];
      end
      return win;
   endfunction

endpackage

// File: rtl/iobus_if.sv
// Requester/bus signal bundle for the two-port I/O bus arbiter.
interface iobus_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);

   // Requester side, port 0 (MCU) and port 1 (debug/host).
   logic          req0;
   logic          req1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wd0;
   logic [DW-1:0] wd1;
   logic          wr0;
   logic          wr1;
   logic          ack0;
   logic          ack1;
   logic [DW-1:0] rd0;
   logic [DW-1:0] rd1;

   // Shared peripheral bus.
   logic [AW-1:0] iobus_addr;
   logic [DW-1:0] iobus_out;
   logic          iobus_wr;
   logic [DW-1:0] iobus_in;

   // Arbiter view.
   modport slave (
      input  req0, req1, addr0, addr1, wd0, wd1, wr0, wr1, iobus_in,
      output ack0, ack1, rd0, rd1, iobus_addr, iobus_out, iobus_wr
   );

   // Requesters plus peripheral mux view.
   modport master (
      output req0, req1, addr0, addr1, wd0, wd1, wr0, wr1, iobus_in,
      input  ack0, ack1, rd0, rd1, iobus_addr, iobus_out, iobus_wr
   );

endinterface

// File: rtl/iobus_arbiter_rr_arb.sv
// Two-way round-robin grant with a priority pointer that moves to the loser on every grant.
module iobus_rr_arb
   import iobus_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic       any,
   output logic       win
);

   logic ptr;

   // Combinational winner selection from the current requests and pointer.
   always_comb begin
      any = |req;
      win = rr_pick(req, ptr);
   end

   // Pointer hands priority to the other port whenever a grant is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (update) begin
         ptr <= ~win;
      end
   end

endmodule

// File: rtl/iobus_arbiter.sv
// Shares the OTTER memory-mapped I/O bus between the MCU (port 0) and a debug/host master (port 1).
module iobus_arbiter
   import iobus_pkg::*;
#(
   parameter int unsigned WAIT_CYC = 1,
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32
) (
   input  logic   clk,
   input  logic   rst_n,
   iobus_if.slave bus
);

   localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYC);

   iobus_state_t      state;
   iobus_state_t      state_nx;
   logic              owner;
   logic              owner_wr;
   logic [WAIT_W-1:0] cnt;

   logic [1:0]        arb_req;
   logic              arb_any;
   logic              arb_win;
   logic              grant;

   logic [AW-1:0]     sel_addr;
   logic [DW-1:0]     sel_wd;
   logic              sel_wr;

   logic [AW-1:0]     iobus_addr_q;
   logic [DW-1:0]     iobus_out_q;
   logic              iobus_wr_q;
   logic              ack0_q;
   logic              ack1_q;
   logic [DW-1:0]     rd0_q;
   logic [DW-1:0]     rd1_q;

   // The owner's own REQ is still high during RESP (it only sees ACK next cycle), so mask it.
   always_comb begin
      arb_req = {bus.req1, bus.req0};
      if (state == ST_RESP) begin
         arb_req[owner] = 1'b0;
      end
   end

   iobus_rr_arb u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (arb_req),
      .update (grant),
      .any    (arb_any),
      .win    (arb_win)
   );

   // Winner's request fields, ready to be registered onto the bus.
   always_comb begin
      sel_addr = arb_win ? bus.addr1 : bus.addr0;
      sel_wd   = arb_win ? bus.wd1   : bus.wd0;
      sel_wr   = arb_win ? bus.wr1   : bus.wr0;
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and grant decode; RESP re-arbitrates so back-to-back requests see no idle bubble.
   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (arb_any) begin
               grant    = 1'b1;
               state_nx = ST_XFER;
            end
         end
         ST_XFER: begin
            state_nx = (WAIT_LD == '0) ? ST_RESP : ST_HOLD;
         end
         ST_HOLD: begin
            if (cnt <= WAIT_W'(1)) begin
               state_nx = ST_RESP;
            end
         end
         ST_RESP: begin
            if (arb_any) begin
               grant    = 1'b1;
               state_nx = ST_XFER;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Wait-state counter: loaded in XFER, counted down through HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state == ST_XFER) begin
         cnt <= WAIT_LD;
      end else if (state == ST_HOLD) begin
         cnt <= cnt - WAIT_W'(1);
      end
   end

   // Bus drive registers; address/data hold between grants, the strobe lives only in XFER.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iobus_addr_q <= '0;
         iobus_out_q  <= '0;
         iobus_wr_q   <= 1'b0;
         owner        <= 1'b0;
         owner_wr     <= 1'b0;
      end else begin
         iobus_wr_q <= 1'b0;
         if (grant) begin
            iobus_addr_q <= sel_addr;
            iobus_out_q  <= sel_wd;
            iobus_wr_q   <= sel_wr;
            owner        <= arb_win;
            owner_wr     <= sel_wr;
         end
      end
   end

   // Completion: one-cycle ACK to the owner and read-data capture on reads only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         rd0_q  <= '0;
         rd1_q  <= '0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         if (state == ST_RESP) begin
            if (owner) begin
               ack1_q <= 1'b1;
               if (!owner_wr) begin
                  rd1_q <= bus.iobus_in;
               end
            end else begin
               ack0_q <= 1'b1;
               if (!owner_wr) begin
                  rd0_q <= bus.iobus_in;
               end
            end
         end
      end
   end

   assign bus.iobus_addr = iobus_addr_q;
   assign bus.iobus_out  = iobus_out_q;
   assign bus.iobus_wr   = iobus_wr_q;
   assign bus.ack0       = ack0_q;
   assign bus.ack1       = ack1_q;
   assign bus.rd0        = rd0_q;
   assign bus.rd1        = rd1_q;

   a_one_ack: assert property (@(posedge clk) disable iff (!rst_n) !(ack0_q && ack1_q));
   a_wr_in_xfer: assert property (@(posedge clk) disable iff (!rst_n) iobus_wr_q |-> (state == ST_XFER));

endmodule

// File: tb/tb_iobus_arbiter.sv
// Bench for iobus_arbiter: vector table and directed sequences, ACKs checked against a scoreboard.
module tb_iobus_arbiter;
   import iobus_pkg::*;

   typedef struct {
      logic        port;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   iobus_if #(.AW(32), .DW(32)) b0 ();
   iobus_if #(.AW(32), .DW(32)) b1 ();

   iobus_arbiter #(.WAIT_CYC(0), .AW(32), .DW(32)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   iobus_arbiter #(.WAIT_CYC(3), .AW(32), .DW(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   always #5 clk = ~clk;

   // Peripheral read mux model.
   function automatic logic [31:0] periph(input logic [31:0] a);
      logic [31:0] v;
      case (a)
         ADDR_SWITCHES: v = 32'h0000_1234;
         ADDR_BUTTONS:  v = 32'h0000_001F;
         ADDR_COUNT:    v = 32'h0000_0ABC;
         default:       v = 32'h0BAD_F00D;
      endcase
      return v;
   endfunction

   assign b0.iobus_in = periph(b0.iobus_addr);
   assign b1.iobus_in = 32'h0;

   txn_t        sb[$];
   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned wr_cnt = 0;
   logic [31:0] last_wa = '0;
   logic [31:0] last_wd = '0;
   logic [31:0] rd_model [2];
   logic [1:0]  ack_now = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   // Per-cycle monitor of dut0: ACKs are matched against the scoreboard head.
   task automatic observe();
      txn_t e;
      ack_now = {b0.ack1, b0.ack0};
      if (b0.ack0 || b0.ack1) begin
         chk("ack_excl", {31'd0, b0.ack0 & b0.ack1}, 32'd0);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_ack: got ack0=%b ack1=%b want none", b0.ack0, b0.ack1);
         end else begin
            e = sb.pop_front();
            chk("ack_port", {31'd0, b0.ack1}, {31'd0, e.port});
            chk("wr_pulses", wr_cnt, e.wr ? 32'd1 : 32'd0);
            if (e.wr) begin
               chk("wr_addr", last_wa, e.addr);
               chk("wr_data", last_wd, e.wd);
            end else begin
               chk("rd_value", e.port ? b0.rd1 : b0.rd0, e.rd);
               rd_model[e.port] = e.rd;
            end
            chk("rd_other_held", e.port ? b0.rd0 : b0.rd1, rd_model[~e.port]);
            wr_cnt = 0;
         end
      end
      if (b0.iobus_wr) begin
         wr_cnt++;
         last_wa = b0.iobus_addr;
         last_wd = b0.iobus_out;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      observe();
   endtask

   task automatic drive_txn(input txn_t t, input logic rq);
      if (t.port) begin
         b0.req1 = rq; b0.wr1 = t.wr; b0.addr1 = t.addr; b0.wd1 = t.wd;
      end else begin
         b0.req0 = rq; b0.wr0 = t.wr; b0.addr0 = t.addr; b0.wd0 = t.wd;
      end
   endtask

   task automatic run_vec(input txn_t t);
      int unsigned n;
      drive_txn(t, 1'b1);
      sb.push_back(t);
      tick();
      n = 1;
      chk("k1_wr_strobe", {31'd0, b0.iobus_wr}, {31'd0, t.wr});
      chk("k1_bus_addr", b0.iobus_addr, t.addr);
      while (ack_now == 2'b00 && n < 20) begin
         tick();
         n++;
      end
      chk("ack_latency", n, 32'd3);
      drive_txn(t, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test want finish");
      $fatal(1);
   end

   initial begin
      txn_t        vec [6];
      txn_t        t;
      txn_t        c0 [2];
      txn_t        c1 [2];
      int unsigned n, i0, i1, acks, last_ack, wpulse, ack_at;

      vec[0] = '{port: 1'b0, wr: 1'b1, addr: ADDR_LEDS,     wd: 32'h0000_A5A5, rd: 32'h0};
      vec[1] = '{port: 1'b1, wr: 1'b0, addr: ADDR_SWITCHES, wd: 32'h0,         rd: 32'h0000_1234};
      vec[2] = '{port: 1'b0, wr: 1'b0, addr: ADDR_BUTTONS,  wd: 32'h0,         rd: 32'h0000_001F};
      vec[3] = '{port: 1'b1, wr: 1'b1, addr: ADDR_COUNT,    wd: 32'h0000_00FF, rd: 32'h0};
      vec[4] = '{port: 1'b1, wr: 1'b0, addr: ADDR_COUNT,    wd: 32'h0,         rd: 32'h0000_0ABC};
      vec[5] = '{port: 1'b0, wr: 1'b0, addr: ADDR_LEDS,     wd: 32'h0,         rd: 32'h0BAD_F00D};

      b0.req0 = 0; b0.req1 = 0; b0.wr0 = 0; b0.wr1 = 0;
      b0.addr0 = '0; b0.addr1 = '0; b0.wd0 = '0; b0.wd1 = '0;
      b1.req0 = 0; b1.req1 = 0; b1.wr0 = 0; b1.wr1 = 0;
      b1.addr0 = '0; b1.addr1 = '0; b1.wd0 = '0; b1.wd1 = '0;
      rd_model[0] = '0;
      rd_model[1] = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_iobus_wr", {31'd0, b0.iobus_wr}, 32'd0);
      chk("rst_ack", {30'd0, b0.ack1, b0.ack0}, 32'd0);
      chk("rst_iobus_addr", b0.iobus_addr, 32'd0);
      chk("rst_iobus_out", b0.iobus_out, 32'd0);
      chk("rst_rd0", b0.rd0, 32'd0);
      chk("rst_rd1", b0.rd1, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Table of single transactions.
      for (int i = 0; i < 6; i++) begin
         run_vec(vec[i]);
         tick();
      end
      chk("idle_addr_hold", b0.iobus_addr, vec[5].addr);
      chk("idle_wr_low", {31'd0, b0.iobus_wr}, 32'd0);

      // REQ0 dropped right after the grant: transaction still completes once.
      t = '{port: 1'b0, wr: 1'b1, addr: ADDR_LEDS, wd: 32'h0000_3C3C, rd: 32'h0};
      drive_txn(t, 1'b1);
      sb.push_back(t);
      tick();
      chk("drop_granted", {31'd0, b0.iobus_wr}, 32'd1);
      drive_txn(t, 1'b0);
      n = 1;
      while (ack_now == 2'b00 && n < 20) begin
         tick();
         n++;
      end
      chk("drop_latency", n, 32'd3);
      chk("drop_ack_port", {30'd0, ack_now}, 32'd1);
      repeat (4) tick();
      chk("drop_no_retx", wr_cnt, 32'd0);
      chk("drop_sb_empty", sb.size(), 32'd0);

      // WAIT_CYC=3 instance: one strobe, address held through HOLD/RESP, ACK five cycles later.
      b1.req0 = 1'b1; b1.wr0 = 1'b1; b1.addr0 = ADDR_LEDS; b1.wd0 = 32'h0000_00C3;
      wpulse = 0;
      ack_at = 0;
      for (int k = 1; k <= 10 && ack_at == 0; k++) begin
         tick();
         if (b1.iobus_wr) wpulse++;
         if (k <= 5) begin
            chk("w3_addr_hold", b1.iobus_addr, ADDR_LEDS);
            chk("w3_wr_shape", {31'd0, b1.iobus_wr}, (k == 1) ? 32'd1 : 32'd0);
         end
         if (b1.ack0) ack_at = k;
      end
      b1.req0 = 1'b0;
      chk("w3_wr_pulses", wpulse, 32'd1);
      chk("w3_ack_cycle", ack_at, 32'd6);
      chk("w3_out", b1.iobus_out, 32'h0000_00C3);

      // Async reset in the middle of a write.
      t = '{port: 1'b0, wr: 1'b1, addr: ADDR_COUNT, wd: 32'h0000_5555, rd: 32'h0};
      drive_txn(t, 1'b1);
      sb.push_back(t);
      tick();
      chk("rst_mid_pre_wr", {31'd0, b0.iobus_wr}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_wr", {31'd0, b0.iobus_wr}, 32'd0);
      chk("rst_mid_ack", {30'd0, b0.ack1, b0.ack0}, 32'd0);
      chk("rst_mid_addr", b0.iobus_addr, 32'd0);
      chk("rst_mid_rd0", b0.rd0, 32'd0);
      sb.delete();
      wr_cnt = 0;
      rd_model[0] = '0;
      rd_model[1] = '0;

      // Contention after reset: port 0 first, then strict alternation with no idle gap.
      c0[0] = '{port: 1'b0, wr: 1'b0, addr: ADDR_SWITCHES, wd: 32'h0,         rd: 32'h0000_1234};
      c0[1] = '{port: 1'b0, wr: 1'b1, addr: ADDR_LEDS,     wd: 32'h0000_005A, rd: 32'h0};
      c1[0] = '{port: 1'b1, wr: 1'b1, addr: ADDR_COUNT,    wd: 32'h0000_0077, rd: 32'h0};
      c1[1] = '{port: 1'b1, wr: 1'b0, addr: ADDR_BUTTONS,  wd: 32'h0,         rd: 32'h0000_001F};
      drive_txn(c0[0], 1'b1);
      drive_txn(c1[0], 1'b1);
      sb.push_back(c0[0]);
      sb.push_back(c1[0]);
      sb.push_back(c0[1]);
      sb.push_back(c1[1]);
      @(posedge clk);
      #1;
      chk("rst_held_ack", {30'd0, b0.ack1, b0.ack0}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      i0 = 0; i1 = 0; acks = 0; last_ack = 0; n = 0;
      while (acks < 4 && n < 40) begin
         tick();
         n++;
         if (ack_now != 2'b00) begin
            if (acks == 0) chk("post_rst_first_ack", n, 32'd3);
            else chk("b2b_gap", n - last_ack, 32'd2);
            last_ack = n;
            acks++;
            if (ack_now[0]) begin
               i0++;
               if (i0 < 2) drive_txn(c0[i0], 1'b1);
               else drive_txn(c0[1], 1'b0);
            end
            if (ack_now[1]) begin
               i1++;
               if (i1 < 2) drive_txn(c1[i1], 1'b1);
               else drive_txn(c1[1], 1'b0);
            end
         end
      end
      chk("contention_acks", acks, 32'd4);
      repeat (3) tick();
      chk("contention_sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
